mem_wr_capture: RTL

MEM_WR_CAPTURE -- requirements
Module: mem_wr_capture

---
 rtl/mem_wr_capture.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_wr_capture.sv
// rtl/mem_wr_capture.sv - captures core data-memory writes into a FIFO for a drain port
//
// Purpose: snoops core writes {addr, data}, queues them in a DEPTH-entry FIFO and
// presents the head entry on a valid/ready drain interface. Writes arriving
// while the FIFO is full (and no pop frees a slot) are dropped and counted.
// Optional feature macro: CAPTURE_FILTER_EN (capture only writes that fall
// inside the 2**WINDOW_BITS byte window at BASE_ADDR).
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_wrValid    core presents a data-memory write this cycle
//   i_memAddr    core write address
//   i_memData    core write data
//   o_valid      head entry available (o_count != 0)
//   i_ready      drain side accepts the head entry
//   o_addr       address field of the head entry
//   o_data       data field of the head entry
//   o_count      current occupancy, 0..DEPTH
//   o_overflow   sticky: a write was dropped
//   o_dropCount  saturating count of dropped writes
//   i_clrOvf     clears o_overflow and o_dropCount (wins over a same-cycle drop)
module mem_wr_capture #(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WINDOW_BITS = 12
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wrValid,
  input  logic [31:0]              i_memAddr,
  input  logic [31:0]              i_memData,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_addr,
  output logic [31:0]              o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [15:0]              o_dropCount,
  input  logic                     i_clrOvf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef CAPTURE_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic [63:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;
  logic [15:0]    r_drop_count;

  logic w_in_window;
  logic w_eligible;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_in_window = (i_memAddr[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
  assign w_eligible  = i_wrValid && (!FILTER_ON || w_in_window);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = (r_count != '0) && i_ready;
  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign w_push      = w_eligible && (!w_full || w_pop);
  assign w_drop      = w_eligible && w_full && !w_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_memAddr, i_memData};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (i_clrOvf) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // Head entry is read straight from the storage registers; reset clears the
  // array so the outputs read zero immediately on reset.
  assign o_valid     = (r_count != '0);
  assign o_addr      = r_mem[r_rd_ptr][63:32];
  assign o_data      = r_mem[r_rd_ptr][31:0];
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_dropCount = r_drop_count;

endmodule
